// File: rtl/imem_boot_controller.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_controller
//  Description : Shares a combinational-read / synchronous-write instruction
//                RAM between the CPU fetch path (RUN) and a word-stream boot
//                loader (LOAD). The core is stalled while an image is written,
//                then gets a one-cycle restart pulse (FLUSH).
//                Optional macro IMEM_FAULT_CHECK_EN adds fetch range and
//                alignment checking with a sticky fault_o flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_controller #(
  parameter int                    MEMORY_DEPTH = 256,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000,
  parameter int                    ADDR_W       = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fetch_addr_i,
  output logic [DATA_WIDTH-1:0] instruction_o,
  input  logic                  load_req_i,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  cpu_stall_o,
  output logic                  cpu_reset_o,
  output logic [ADDR_W:0]       words_loaded_o,
  output logic                  fault_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MEMORY_DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] w_offset;
  logic [ADDR_W-1:0]     w_fetch_idx;
  logic                  w_fetch_bad;
  logic                  w_unused_offset;

  // PC byte address to RAM word index; out-of-range indices wrap modulo depth.
  assign w_offset        = fetch_addr_i - BASE_ADDR;
  assign w_fetch_idx     = w_offset[ADDR_W+1:2];
  assign w_unused_offset = ^w_offset;
  assign mem_wdata_o     = load_data_i;
  assign words_loaded_o  = cnt_q;

`ifdef IMEM_FAULT_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] DEPTH_WORDS = DATA_WIDTH'(MEMORY_DEPTH);

  logic fault_q, fault_d;

  // A below-base address also wraps to a huge index, but it is checked explicitly.
  assign w_fetch_bad = (fetch_addr_i[1:0] != 2'b00) ||
                       (fetch_addr_i < BASE_ADDR) ||
                       ({2'b00, w_offset[DATA_WIDTH-1:2]} >= DEPTH_WORDS);
  assign fault_o     = fault_q;

  // Sticky fault: cleared when a load starts, set by a bad fetch in RUN.
  always_comb begin
    fault_d = fault_q;
    if (state_q == ST_RUN) begin
      if (load_req_i) begin
        fault_d = 1'b0;
      end else if (w_fetch_bad) begin
        fault_d = 1'b1;
      end
    end
  end

  // Fault flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign w_fetch_bad = 1'b0;
  assign fault_o     = 1'b0;
`endif

  // Next-state and output decode for the RUN / LOAD / FLUSH sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_addr_o    = w_fetch_idx;
    mem_we_o      = 1'b0;
    load_ready_o  = 1'b0;
    cpu_stall_o   = 1'b0;
    cpu_reset_o   = 1'b0;
    instruction_o = '0;
    case (state_q)
      ST_RUN: begin
        instruction_o = w_fetch_bad ? '0 : mem_rdata_i;
        if (load_req_i) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        cpu_stall_o  = 1'b1;
        load_ready_o = 1'b1;
        mem_addr_o   = cnt_q[ADDR_W-1:0];
        mem_we_o     = load_valid_i;
        if (load_valid_i) begin
          cnt_d = cnt_q + CNT_ONE;
          // The image is truncated at the RAM depth rather than wrapping.
          if (load_last_i || (cnt_q == LAST_IDX)) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        cpu_stall_o = 1'b1;
        cpu_reset_o = 1'b1;
        state_d     = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and word-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_controller
//  Description : Randomized scoreboard bench for imem_boot_controller with a
//                RAM model and a reference model of loads and fetches.
//                Honours IMEM_FAULT_CHECK_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_controller;

  localparam int          DEPTH = 256;
  localparam int          AW    = 8;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk          = 1'b0;
  logic        reset        = 1'b1;
  logic [31:0] fetch_addr_i = BASE;
  logic        load_req_i   = 1'b0;
  logic        load_valid_i = 1'b0;
  logic [31:0] load_data_i  = '0;
  logic        load_last_i  = 1'b0;
  logic [31:0] mem_rdata_i;
  logic [31:0] instruction_o;
  logic        load_ready_o;
  logic [AW-1:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic        cpu_stall_o;
  logic        cpu_reset_o;
  logic [AW:0] words_loaded_o;
  logic        fault_o;

  imem_boot_controller dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_addr_i   (fetch_addr_i),
    .instruction_o  (instruction_o),
    .load_req_i     (load_req_i),
    .load_valid_i   (load_valid_i),
    .load_data_i    (load_data_i),
    .load_last_i    (load_last_i),
    .load_ready_o   (load_ready_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .cpu_stall_o    (cpu_stall_o),
    .cpu_reset_o    (cpu_reset_o),
    .words_loaded_o (words_loaded_o),
    .fault_o        (fault_o)
  );

  typedef struct { int addr; logic [31:0] data; } wr_t;
  typedef struct { int addr; logic [31:0] instr; logic fault; } fe_t;

  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_ram [DEPTH];
  wr_t         exp_wr[$];
  fe_t         exp_fe[$];
  int          exp_rst[$];

  int cyc       = 0;
  int errors    = 0;
  int checks    = 0;
  int run_cyc   = -1;
  int run_words = 0;
  bit ref_fault = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction RAM: combinational read, write on the rising edge.
  always @(posedge clk) if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
  assign mem_rdata_i = ram[mem_addr_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected writes, restart pulses and fetch results.
  initial begin : monitor
    wr_t w;
    fe_t f;
    int  r;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (mem_we_o) begin
          chk("wr_pending", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(mem_addr_o), w.addr);
            chk("wr_data", mem_wdata_o, w.data);
          end
        end
        if (cpu_reset_o) begin
          chk("rst_pending", 32'(exp_rst.size() > 0), 32'd1);
          if (exp_rst.size() > 0) begin
            r = exp_rst.pop_front();
            chk("rst_cycle", cyc, r);
          end
        end
        if (!cpu_stall_o && exp_fe.size() > 0) begin
          f = exp_fe.pop_front();
          chk("fetch_addr", 32'(mem_addr_o), f.addr);
          chk("fetch_instr", instruction_o, f.instr);
          chk("fetch_fault", 32'(fault_o), 32'(f.fault));
        end
      end
    end
  end

  // One fetch cycle; expected result from byte-address arithmetic.
  task automatic fetch(input logic [31:0] a);
    logic [31:0] off;
    logic        bad;
    fe_t         f;
    @(negedge clk);
    fetch_addr_i = a;
    off = a - BASE;
    bad = 1'b0;
`ifdef IMEM_FAULT_CHECK_EN
    bad = (a[1:0] != 2'b00) || (a < BASE) || ((off >> 2) >= DEPTH);
`endif
    f.addr  = int'(off[9:2]);
    f.instr = bad ? 32'd0 : ref_ram[off[9:2]];
    f.fault = ref_fault;
    exp_fe.push_back(f);
    ref_fault = ref_fault | bad;
  endtask

  task automatic run_check();
    if (cyc == run_cyc) begin
      chk("run_stall", 32'(cpu_stall_o), 32'd0);
      chk("run_words", 32'(words_loaded_o), run_words);
      run_cyc = -1;
    end
  endtask

  // Loads n words; last_idx<0 means no load_last_i, rst_at>=0 resets mid-image.
  task automatic do_load(input int n, input int last_idx, input int gap_at,
                         input int gap_len, input int rst_at, input bit fixed);
    int          limit;
    bit          aborted;
    logic [31:0] d;
    wr_t         w;
    limit   = (last_idx >= 0 && last_idx < n) ? last_idx + 1 : n;
    if (limit > DEPTH) limit = DEPTH;
    aborted = 1'b0;
    @(negedge clk);
    fetch_addr_i = BASE;
    load_req_i   = 1'b1;
    ref_fault    = 1'b0;
    @(negedge clk);
    load_req_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          load_valid_i = 1'b0;
          #2;
          chk("gap_we", 32'(mem_we_o), 32'd0);
          chk("gap_stall", 32'(cpu_stall_o), 32'd1);
          chk("gap_count", 32'(words_loaded_o), i);
          @(negedge clk);
        end
      end
      if (i == rst_at) begin
        load_valid_i = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("abort_stall", 32'(cpu_stall_o), 32'd0);
        chk("abort_restart", 32'(cpu_reset_o), 32'd0);
        chk("abort_words", 32'(words_loaded_o), 32'd0);
        chk("abort_ready", 32'(load_ready_o), 32'd0);
        aborted = 1'b1;
        break;
      end
      d = fixed ? 32'h11 * (i + 1) : $urandom;
      load_valid_i = 1'b1;
      load_data_i  = d;
      load_last_i  = (i == last_idx);
      if (i < limit) begin
        w.addr = i;
        w.data = d;
        exp_wr.push_back(w);
        ref_ram[i] = d;
        if (i == limit - 1) begin
          exp_rst.push_back(cyc + 1);
          run_cyc   = cyc + 2;
          run_words = limit;
        end
      end
      #2;
      if (i == 0) begin
        chk("load_stall", 32'(cpu_stall_o), 32'd1);
        chk("load_ready", 32'(load_ready_o), 32'd1);
        chk("load_nop", instruction_o, 32'd0);
      end
      if (i >= limit) chk("trunc_ready", 32'(load_ready_o), 32'd0);
      run_check();
      @(negedge clk);
    end
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    if (!aborted) begin
      for (int k = 0; k < 4; k++) begin
        #2;
        run_check();
        @(negedge clk);
      end
      chk("run_reached", run_cyc, -1);
      run_cyc = -1;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      ram[i]     = v;
      ref_ram[i] = v;
    end
    ram[2]     = 32'h2010_0005;
    ref_ram[2] = 32'h2010_0005;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_stall", 32'(cpu_stall_o), 32'd0);
    chk("rst_restart", 32'(cpu_reset_o), 32'd0);
    chk("rst_ready", 32'(load_ready_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_words", 32'(words_loaded_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);

    fetch(32'h0040_0008);
    repeat (20) fetch(BASE + 32'($urandom_range(0, DEPTH - 1)) * 4);

    do_load(3, 2, -1, 0, -1, 1'b1);
    fetch(BASE);
    fetch(BASE + 4);
    fetch(BASE + 8);

    do_load(6, 5, 3, 4, -1, 1'b0);
    repeat (3) begin
      v = 32'($urandom_range(1, 12));
      do_load(int'(v), int'(v) - 1, int'($urandom_range(0, 11)),
              int'($urandom_range(1, 3)), -1, 1'b0);
    end
    do_load(260, -1, -1, 0, -1, 1'b0);
    do_load(8, 7, -1, 0, 5, 1'b0);

    repeat (30) fetch(BASE - 32'd1024 + 32'($urandom_range(0, 4095)));
    fetch(32'h0040_0402);
    fetch(BASE + 4);
    fetch(BASE + 12);
    do_load(1, 0, -1, 0, -1, 1'b0);
    fetch(BASE);
    fetch(BASE + 32'd1020);

    repeat (3) @(negedge clk);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("rst_queue_empty", 32'(exp_rst.size()), 32'd0);
    chk("fetch_queue_empty", 32'(exp_fe.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
